fpu_cmd_sequencer: RTL and testbench
====================================

// Module: fpu_cmd_sequencer
// PURPOSE
//  Upstream feeder for the FPU wrapper. Buffers operand/op commands in a small FIFO.
//  Issues one command at a time: operands plus a 1-cycle start pulse.
//  Waits a fixed latency, captures Y/error/over_flow, then returns them on a valid/ready response port.
//  Never more than one command in flight at the FPU.
// PARAMETERS
//  DEPTH    4  command FIFO entries (power of 2, >=2)
//  LATENCY  4  cycles after the start-pulse cycle before the FPU result is sampled (>=1)
// PORTS
//  clk            in   1   single clock; all logic on posedge
//  reset          in   1   synchronous, active-high reset
//  cmd_valid      in   1   command offered
//  cmd_ready      out  1   FIFO can accept (= !full)
//  cmd_a          in   32  operand A (IEEE-754 single)
//  cmd_b          in   32  operand B
//  cmd_sel        in   2   FPU operation select
//  cmd_round      in   1   rounding mode
//  fpu_A          out  32  to FPU A
//  fpu_B          out  32  to FPU B
//  fpu_sel        out  2   to FPU sel
//  fpu_round_mode out  1   to FPU round_mode
//  fpu_start      out  1   1-cycle issue pulse
//  fpu_Y          in   32  FPU result
//  fpu_error      in   1   FPU error flag
//  fpu_over_flow  in   1   FPU overflow flag
//  rsp_valid      out  1   result held, awaiting consumer
//  rsp_ready      in   1   consumer accepts result
//  rsp_y          out  32  captured result
//  rsp_error      out  1   captured error
//  rsp_over_flow  out  1   captured overflow
//  busy           out  1   state != IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset: all outputs 0; cmd_ready=1 after reset deasserts. FIFO is emptied, state=IDLE, counter=0.
//  Reset mid-operation: the in-flight command and all queued commands are discarded; no response is produced.
//  FIFO: push on cmd_valid&&cmd_ready.
//   - Pop only in IDLE->ISSUE.
//   - Push and pop in the same cycle are allowed; count is unchanged.
//   - cmd_ready depends on registered full only. No bypass: a full FIFO refuses input even during a pop.
//   - Pointers wrap modulo DEPTH; count is $clog2(DEPTH+1) bits.
//  FSM, registered state:
//   - IDLE: if !empty -> ISSUE; head is loaded into the fpu_* operand regs and popped.
//   - ISSUE: fpu_start=1 for exactly this cycle. Counter <= 1. -> WAIT.
//   - WAIT: fpu_start=0; operands held stable. When counter==LATENCY, capture fpu_Y/fpu_error/fpu_over_flow
//     into rsp_* -> RESP; else counter++.
//   - RESP: rsp_valid=1; rsp_* held stable. On rsp_ready -> IDLE.
//  Timing: start pulse in cycle c; sampled at the end of cycle c+LATENCY; rsp_valid high from c+LATENCY+1.
//  Back-to-back: the next start occurs no earlier than 2 cycles after the response handshake.
//   - Min issue interval = LATENCY+3 cycles with rsp_ready tied high.
//  fpu_* operand outputs keep their last issued value in IDLE/RESP; they are never driven to X.
//  rsp_ready while !rsp_valid is ignored. cmd_valid while !cmd_ready: command is dropped, no error.
//  rsp_valid must not drop without rsp_ready.
// STRUCTURE
//  Package fpu_pkg:
//   - typedef fpu_cmd_t {a[31:0], b[31:0], sel[1:0], round}
//   - typedef fpu_rsp_t {y[31:0], error, over_flow}
//   - state enum {IDLE, ISSUE, WAIT, RESP}
//   - localparam FPU_SEL_W=2
//  Sub-module fpu_cmd_fifo: synchronous FIFO of fpu_cmd_t, params DEPTH; ports push/pop/full/empty/count.
//  Top holds the FSM, latency counter and response registers.
// TESTING
//  Bench models the FPU as a LATENCY-cycle pipeline keyed on the start pulse.
//  1 Single cmd: a=32'h3F800000, b=32'h40000000, sel=0 -> one start pulse, rsp_y=model result,
//    rsp_valid at issue+LATENCY+1.
//  2 Fill: DEPTH+1 cmds with rsp_ready=1 -> cmd_ready low after DEPTH accepted while 1st is in flight;
//    responses return in order with no loss.
//  3 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid/rsp_y stable; no new fpu_start until handshake.
//  4 Flags: model forces error=1, over_flow=1 -> rsp_error=1, rsp_over_flow=1 for that response only.
//  5 Reset in WAIT with 2 queued cmds -> next cycle all outputs 0, empty, cmd_ready=1;
//    no rsp_valid afterwards.
//  6 Push+pop same cycle at count=1 -> count stays 1; pointer wrap verified over 3*DEPTH commands.

Source files
------------

// File: rtl/fpu_cmd_sequencer_pkg.sv
// Shared types for the FPU command sequencer: command/response payloads and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fpu_pkg;

  localparam int FPU_SEL_W = 2;

  typedef struct packed {
    logic [31:0]          a;
    logic [31:0]          b;
    logic [FPU_SEL_W-1:0] sel;
    logic                 round;
  } fpu_cmd_t;

  typedef struct packed {
    logic [31:0] y;
    logic        error;
    logic        over_flow;
  } fpu_rsp_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

endpackage

// File: rtl/fpu_cmd_sequencer_if.sv
// Bundles the command, FPU-side and response signals of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: cmd_valid/cmd_ready on the command side, rsp_valid/rsp_ready on the response side.
interface fpu_cmd_sequencer_if;
  import fpu_pkg::*;

  // command side
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [31:0]          cmd_a;
  logic [31:0]          cmd_b;
  logic [FPU_SEL_W-1:0] cmd_sel;
  logic                 cmd_round;

  // FPU side
  logic [31:0]          fpu_A;
  logic [31:0]          fpu_B;
  logic [FPU_SEL_W-1:0] fpu_sel;
  logic                 fpu_round_mode;
  logic                 fpu_start;
  logic [31:0]          fpu_Y;
  logic                 fpu_error;
  logic                 fpu_over_flow;

  // response side
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_y;
  logic                 rsp_error;
  logic                 rsp_over_flow;

  logic                 busy;

  // sequencer view
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_round,
    input  fpu_Y, fpu_error, fpu_over_flow,
    input  rsp_ready,
    output cmd_ready,
    output fpu_A, fpu_B, fpu_sel, fpu_round_mode, fpu_start,
    output rsp_valid, rsp_y, rsp_error, rsp_over_flow,
    output busy
  );

  // environment view (command source, FPU, response sink)
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_round,
    output fpu_Y, fpu_error, fpu_over_flow,
    output rsp_ready,
    input  cmd_ready,
    input  fpu_A, fpu_B, fpu_sel, fpu_round_mode, fpu_start,
    input  rsp_valid, rsp_y, rsp_error, rsp_over_flow,
    input  busy
  );

endinterface

// File: rtl/fpu_cmd_sequencer_fifo.sv
// Synchronous command FIFO, DEPTH entries of fpu_cmd_t, head visible combinationally.
// Latency: a pushed entry is poppable the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored; no full-bypass.
module fpu_cmd_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  fpu_cmd_t                   i_push_dat,
  input  logic                       i_pop,
  output fpu_cmd_t                   o_pop_dat,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  fpu_cmd_t        r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full    = (r_count == FULL_C);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_pop_dat = r_mem[r_rd_ptr];
  assign w_push    = i_push && !o_full;
  assign w_pop     = i_pop && !o_empty;

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; an entry is only read after it has been written.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/fpu_cmd_sequencer.sv
// Feeds buffered commands to the FPU one at a time and returns each result on a valid/ready port.
// Latency: start pulse 2 cycles after an idle push; response valid LATENCY+1 cycles after the start pulse.
// Backpressure: cmd_ready = !full; a held response stalls further issue until rsp_ready.
module fpu_cmd_sequencer
  import fpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  fpu_cmd_sequencer_if.slave   bus
);

  localparam int CW    = $clog2(DEPTH+1);
  localparam int CNT_W = $clog2(LATENCY+1);
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  fpu_cmd_t         r_op;
  fpu_rsp_t         r_rsp;

  fpu_cmd_t         w_push_dat;
  fpu_cmd_t         w_head;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;

  assign w_push_dat.a     = bus.cmd_a;
  assign w_push_dat.b     = bus.cmd_b;
  assign w_push_dat.sel   = bus.cmd_sel;
  assign w_push_dat.round = bus.cmd_round;
  assign w_push           = bus.cmd_valid && !w_full;

  fpu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_pop_dat  (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state; the FIFO head is popped only on the IDLE->ISSUE transition.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_state_nxt = ISSUE;
          w_pop       = 1'b1;
        end
      end
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    if (r_cnt == LAT_C) w_state_nxt = RESP;
      RESP:    if (bus.rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand load at pop, latency count from the start pulse, result capture at the sample cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_rsp <= '0;
    end else begin
      if (w_pop) r_op <= w_head;
      if (r_state == ISSUE) begin
        r_cnt <= CNT_W'(1);
      end else if (r_state == WAIT) begin
        if (r_cnt == LAT_C) begin
          r_rsp.y         <= bus.fpu_Y;
          r_rsp.error     <= bus.fpu_error;
          r_rsp.over_flow <= bus.fpu_over_flow;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.cmd_ready      = !w_full;
  assign bus.fpu_A          = r_op.a;
  assign bus.fpu_B          = r_op.b;
  assign bus.fpu_sel        = r_op.sel;
  assign bus.fpu_round_mode = r_op.round;
  assign bus.fpu_start      = (r_state == ISSUE);
  assign bus.rsp_valid      = (r_state == RESP);
  assign bus.rsp_y          = r_rsp.y;
  assign bus.rsp_error      = r_rsp.error;
  assign bus.rsp_over_flow  = r_rsp.over_flow;
  assign bus.busy           = (r_state != IDLE) || (w_count != '0);

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// Self-checking bench for fpu_cmd_sequencer: FPU model, timestamp-based reference model, directed + random stimulus.
// Latency: n/a.
// Backpressure: rsp_ready driven directed and randomly.
module tb_fpu_cmd_sequencer;
  import fpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fpu_cmd_sequencer_if ifc();

  fpu_cmd_sequencer #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (ifc.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Arbitrary but fixed FPU function; flags keyed on operand top bytes.
  function automatic fpu_rsp_t ref_fpu(input fpu_cmd_t c);
    fpu_rsp_t    r;
    logic [31:0] v;
    case (c.sel)
      2'd0:    v = c.a + c.b;
      2'd1:    v = c.a - c.b;
      2'd2:    v = c.a ^ c.b;
      default: v = c.a & c.b;
    endcase
    r.y         = v ^ {31'b0, c.round};
    r.error     = (c.b[31:24] == 8'hEE);
    r.over_flow = (c.a[31:24] == 8'h7F);
    return r;
  endfunction

  function automatic fpu_cmd_t mk(input logic [31:0] a, input logic [31:0] b,
                                  input logic [1:0] sel, input logic rnd);
    fpu_cmd_t c;
    c.a = a; c.b = b; c.sel = sel; c.round = rnd;
    return c;
  endfunction

  // Reference model state (timestamps, not FSM encoding).
  fpu_cmd_t mq[$];
  fpu_cmd_t m_cur;
  fpu_cmd_t m_last;
  bit       m_have = 1'b0;
  bit       m_en   = 1'b0;
  int       m_start = 0;
  int       cyc = 0;
  int       n_rsp = 0;
  int       n_start = 0;

  // FPU model: one result, valid only during cycle start+LAT.
  bit       f_pend = 1'b0;
  int       f_due = 0;
  fpu_rsp_t f_res;

  // Mid-cycle: drive the FPU model, compare DUT to the reference, then advance the reference.
  always @(negedge clk) begin : cmp
    fpu_cmd_t seen;
    fpu_cmd_t inc;
    fpu_rsp_t er;
    bit e_start, e_rv, e_crdy, hs, popnow;

    if (ifc.fpu_start === 1'b1) begin
      seen.a = ifc.fpu_A; seen.b = ifc.fpu_B;
      seen.sel = ifc.fpu_sel; seen.round = ifc.fpu_round_mode;
      f_res  = ref_fpu(seen);
      f_due  = cyc + LAT;
      f_pend = 1'b1;
      n_start++;
    end
    if (f_pend && cyc == f_due) begin
      ifc.fpu_Y         = f_res.y;
      ifc.fpu_error     = f_res.error;
      ifc.fpu_over_flow = f_res.over_flow;
      f_pend = 1'b0;
    end else begin
      ifc.fpu_Y         = $urandom;
      ifc.fpu_error     = 1'($urandom);
      ifc.fpu_over_flow = 1'($urandom);
    end

    e_start = m_have && (cyc == m_start);
    e_rv    = m_have && (cyc >= m_start + LAT + 1);
    e_crdy  = (mq.size() < DEPTH);
    if (m_en) begin
      chk("fpu_start", 32'(ifc.fpu_start), 32'(e_start));
      chk("rsp_valid", 32'(ifc.rsp_valid), 32'(e_rv));
      chk("cmd_ready", 32'(ifc.cmd_ready), 32'(e_crdy));
      chk("busy",      32'(ifc.busy), 32'(m_have || mq.size() != 0));
      chk("count",     32'(dut.u_fifo.o_count), 32'(mq.size()));
      chk("fpu_A",     ifc.fpu_A, m_last.a);
      chk("fpu_B",     ifc.fpu_B, m_last.b);
      chk("fpu_selrnd", 32'({ifc.fpu_sel, ifc.fpu_round_mode}), 32'({m_last.sel, m_last.round}));
      if (e_rv) begin
        er = ref_fpu(m_cur);
        chk("rsp_y", ifc.rsp_y, er.y);
        chk("rsp_flags", 32'({ifc.rsp_error, ifc.rsp_over_flow}), 32'({er.error, er.over_flow}));
      end
    end

    if (reset) begin
      mq.delete();
      m_have = 1'b0;
      m_last = '0;
      m_en   = 1'b1;
    end else if (m_en) begin
      hs     = e_rv && ifc.rsp_ready;
      popnow = !m_have && (mq.size() > 0);
      if (hs) begin
        m_have = 1'b0;
        n_rsp++;
      end
      if (popnow) begin
        m_cur   = mq.pop_front();
        m_last  = m_cur;
        m_have  = 1'b1;
        m_start = cyc + 1;
      end
      if (ifc.cmd_valid && e_crdy) begin
        inc.a = ifc.cmd_a; inc.b = ifc.cmd_b;
        inc.sel = ifc.cmd_sel; inc.round = ifc.cmd_round;
        mq.push_back(inc);
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input fpu_cmd_t c);
    ifc.cmd_a = c.a; ifc.cmd_b = c.b; ifc.cmd_sel = c.sel; ifc.cmd_round = c.round;
  endtask

  function automatic fpu_cmd_t rnd_cmd();
    return mk($urandom, $urandom, 2'($urandom), 1'($urandom));
  endfunction

  task automatic send(input fpu_cmd_t c);
    int n;
    bit acc;
    drive(c);
    ifc.cmd_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      acc = ifc.cmd_ready;
      tick();
      n++;
    end
    ifc.cmd_valid = 1'b0;
    chk("send_accept", 32'(acc), 32'd1);
  endtask

  // which: 0 = fpu_start, 1 = rsp_valid, 2 = not busy
  task automatic wait_for(input string nm, input int which);
    int  n;
    bit  hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 300) begin
      case (which)
        0:       hit = (ifc.fpu_start === 1'b1);
        1:       hit = (ifc.rsp_valid === 1'b1);
        default: hit = (ifc.busy === 1'b0);
      endcase
      if (!hit) begin
        tick();
        n++;
      end
    end
    chk(nm, 32'(hit), 32'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    fpu_cmd_t c;
    int k;
    int acc;
    int r0;
    int s0;
    bit rv_seen;

    ifc.cmd_valid = 1'b0;
    ifc.cmd_a = '0; ifc.cmd_b = '0; ifc.cmd_sel = '0; ifc.cmd_round = 1'b0;
    ifc.rsp_ready = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // reset state
    chk("rst_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    chk("rst_start", 32'(ifc.fpu_start), 32'd0);
    chk("rst_fpu_A", ifc.fpu_A, 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_rsp_y", ifc.rsp_y, 32'd0);

    // 1: single command, latency and literal result
    c = mk(32'h3F80_0000, 32'h4000_0000, 2'd0, 1'b0);
    send(c);
    wait_for("t1_start", 0);
    k = 0;
    while (!ifc.rsp_valid && k < 50) begin
      tick();
      k++;
    end
    chk("t1_latency", k, LAT + 1);
    chk("t1_y", ifc.rsp_y, 32'h7F80_0000);
    chk("t1_flags", 32'({ifc.rsp_error, ifc.rsp_over_flow}), 32'd0);
    ifc.rsp_ready = 1'b1;
    tick();
    wait_for("t1_idle", 2);

    // 2: fill with DEPTH+1 commands while the first is in flight
    acc = 0;
    r0 = n_rsp;
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(rnd_cmd());
      ifc.cmd_valid = 1'b1;
      if (ifc.cmd_ready) acc++;
      tick();
    end
    chk("t2_accepted", acc, DEPTH + 1);
    chk("t2_full_ready", 32'(ifc.cmd_ready), 32'd0);
    ifc.cmd_valid = 1'b0;
    wait_for("t2_idle", 2);
    chk("t2_responses", n_rsp - r0, DEPTH + 1);

    // 3: response backpressure for 10 cycles with a second command queued
    ifc.rsp_ready = 1'b0;
    c = rnd_cmd();
    send(c);
    send(rnd_cmd());
    wait_for("t3_rv", 1);
    s0 = n_start;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_valid_held", 32'(ifc.rsp_valid), 32'd1);
      chk("t3_y_held", ifc.rsp_y, ref_fpu(c).y);
    end
    chk("t3_no_start", n_start - s0, 0);
    ifc.rsp_ready = 1'b1;
    wait_for("t3_idle", 2);

    // 4: flags set for one response only
    ifc.rsp_ready = 1'b0;
    send(mk(32'h7F12_3456, 32'hEE00_0001, 2'd2, 1'b1));
    send(mk(32'h0000_0010, 32'h0000_0020, 2'd0, 1'b0));
    wait_for("t4_rv1", 1);
    chk("t4_flags1", 32'({ifc.rsp_error, ifc.rsp_over_flow}), 32'd3);
    chk("t4_y1", ifc.rsp_y, 32'h9112_3456);
    ifc.rsp_ready = 1'b1;
    tick();
    ifc.rsp_ready = 1'b0;
    wait_for("t4_rv2", 1);
    chk("t4_flags2", 32'({ifc.rsp_error, ifc.rsp_over_flow}), 32'd0);
    chk("t4_y2", ifc.rsp_y, 32'h0000_0030);
    ifc.rsp_ready = 1'b1;
    wait_for("t4_idle", 2);

    // 5: reset while waiting on the FPU with two commands queued
    send(rnd_cmd());
    send(rnd_cmd());
    send(rnd_cmd());
    tick();
    chk("t5_queued", 32'(dut.u_fifo.o_count), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
    chk("t5_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    chk("t5_start", 32'(ifc.fpu_start), 32'd0);
    chk("t5_fpu_A", ifc.fpu_A, 32'd0);
    chk("t5_fpu_B", ifc.fpu_B, 32'd0);
    chk("t5_rsp_y", ifc.rsp_y, 32'd0);
    chk("t5_busy", 32'(ifc.busy), 32'd0);
    chk("t5_count", 32'(dut.u_fifo.o_count), 32'd0);
    rv_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ifc.rsp_valid !== 1'b0) rv_seen = 1'b1;
    end
    chk("t5_no_rsp", 32'(rv_seen), 32'd0);

    // 6: push and pop in the same cycle at count 1
    drive(rnd_cmd());
    ifc.cmd_valid = 1'b1;
    tick();
    chk("t6_count_before", 32'(dut.u_fifo.o_count), 32'd1);
    drive(rnd_cmd());
    tick();
    ifc.cmd_valid = 1'b0;
    chk("t6_count_after", 32'(dut.u_fifo.o_count), 32'd1);
    wait_for("t6_idle", 2);

    // pointer wrap and random traffic: at least 3*DEPTH accepted commands
    acc = 0;
    k = 0;
    while ((acc < 3 * DEPTH || k < 400) && k < 5000) begin
      drive(rnd_cmd());
      ifc.cmd_valid = 1'($urandom);
      ifc.rsp_ready = 1'($urandom);
      if (ifc.cmd_valid && ifc.cmd_ready) acc++;
      tick();
      k++;
    end
    ifc.cmd_valid = 1'b0;
    ifc.rsp_ready = 1'b1;
    chk("rand_enough_cmds", 32'(acc >= 3 * DEPTH), 32'd1);
    wait_for("rand_idle", 2);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
